// File: rtl/forward_hazard_unit_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard unit:
// operand-mux select encodings and the per-stage instruction record.
package forward_hazard_unit_pkg;

  // Record index fields are sized for the widest supported register file;
  // narrower instances zero-extend, which leaves all index compares intact.
  localparam int unsigned MAX_REG_ADDR_W = 8;

  typedef logic [MAX_REG_ADDR_W-1:0] ridx_t;

  // EX operand-mux selects, shared with the datapath mux instances.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,  // register-file read value
    FWD_WB  = 2'b01,  // MEM/WB result
    FWD_MEM = 2'b10   // EX/MEM result
  } fwd_sel_e;

  // Book-keeping for one pipeline stage.
  typedef struct packed {
    logic  valid;
    ridx_t rs;
    ridx_t rt;
    ridx_t rd;
    logic  regwrite;
    logic  memread;
  } stage_rec_t;

  // True when a stage will write a real (non-zero) register equal to src.
  function automatic logic writes_src(input logic regwrite, input ridx_t rd, input ridx_t src);
    return regwrite && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/forward_hazard_unit_fwd_select.sv
// One EX operand select: picks the youngest in-flight producer of src.
module fwd_select
  import forward_hazard_unit_pkg::*;
(
  input  ridx_t    i_src,
  input  logic     i_mem_regwrite,
  input  ridx_t    i_mem_rd,
  input  logic     i_wb_regwrite,
  input  ridx_t    i_wb_rd,
  output fwd_sel_e o_sel
);

  // MEM is checked first so the most recent result wins over WB.
  always_comb begin
    o_sel = FWD_REG;
    if (writes_src(i_mem_regwrite, i_mem_rd, i_src)) begin
      o_sel = FWD_MEM;
    end else if (writes_src(i_wb_regwrite, i_wb_rd, i_src)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard unit for a classic 5-stage pipeline.
// Tracks EX/MEM/WB instruction records internally and produces the EX
// operand-mux selects plus a one-cycle load-use stall request.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  output logic                  stall_o,
  output logic [1:0]            ex_fwd_a_o,
  output logic [1:0]            ex_fwd_b_o
);

  if (REG_ADDR_W == 0 || REG_ADDR_W > MAX_REG_ADDR_W) begin : g_bad_width
    $error("forward_hazard_unit: REG_ADDR_W out of range");
  end

  stage_rec_t r_ex;
  stage_rec_t r_mem;
  stage_rec_t r_wb;

  stage_rec_t w_id_rec;
  fwd_sel_e   w_sel_a;
  fwd_sel_e   w_sel_b;
  logic       w_stall;

  // Zero-extend the ID fields into a stage record.
  always_comb begin
    w_id_rec          = '0;
    w_id_rec.valid    = id_valid_i;
    w_id_rec.rs       = ridx_t'(id_rs_i);
    w_id_rec.rt       = ridx_t'(id_rt_i);
    w_id_rec.rd       = ridx_t'(id_rd_i);
    w_id_rec.regwrite = id_regwrite_i;
    w_id_rec.memread  = id_memread_i;
  end

  // Load-use hazard: a load in EX whose destination is read by ID.
  always_comb begin
    w_stall = id_valid_i && r_ex.valid && r_ex.memread && r_ex.regwrite &&
              (r_ex.rd != '0) &&
              ((r_ex.rd == w_id_rec.rs) || (id_uses_rt_i && (r_ex.rd == w_id_rec.rt)));
  end

  // Stage shift; a stall or an empty ID slot inserts a bubble into EX
  // while older instructions keep draining.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (w_stall || !id_valid_i) begin
        r_ex <= '0;
      end else begin
        r_ex <= w_id_rec;
      end
    end
  end

  fwd_select u_fwd_a (
    .i_src          (r_ex.rs),
    .i_mem_regwrite (r_mem.regwrite),
    .i_mem_rd       (r_mem.rd),
    .i_wb_regwrite  (r_wb.regwrite),
    .i_wb_rd        (r_wb.rd),
    .o_sel          (w_sel_a)
  );

  fwd_select u_fwd_b (
    .i_src          (r_ex.rt),
    .i_mem_regwrite (r_mem.regwrite),
    .i_mem_rd       (r_mem.rd),
    .i_wb_regwrite  (r_wb.regwrite),
    .i_wb_rd        (r_wb.rd),
    .o_sel          (w_sel_b)
  );

  // Selects are meaningless without a real instruction in EX.
  always_comb begin
    stall_o    = w_stall;
    ex_fwd_a_o = r_ex.valid ? w_sel_a : FWD_REG;
    ex_fwd_b_o = r_ex.valid ? w_sel_b : FWD_REG;
  end

  // Fields carried only for completeness of the stage records.
  logic w_unused;
  assign w_unused = &{1'b0, r_mem.valid, r_mem.rs, r_mem.rt, r_mem.memread,
                      r_wb.valid, r_wb.rs, r_wb.rt, r_wb.memread};

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Randomised + directed bench for forward_hazard_unit with a scoreboard.
module tb_forward_hazard_unit;

  localparam int W = 5;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         id_valid_i;
  logic [W-1:0] id_rs_i;
  logic [W-1:0] id_rt_i;
  logic         id_uses_rt_i;
  logic [W-1:0] id_rd_i;
  logic         id_regwrite_i;
  logic         id_memread_i;
  logic         stall_o;
  logic [1:0]   ex_fwd_a_o;
  logic [1:0]   ex_fwd_b_o;

  always #5 clk_i = ~clk_i;

  forward_hazard_unit #(.REG_ADDR_W(W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_uses_rt_i  (id_uses_rt_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .stall_o       (stall_o),
    .ex_fwd_a_o    (ex_fwd_a_o),
    .ex_fwd_b_o    (ex_fwd_b_o)
  );

  typedef struct {
    bit v;
    int rs;
    int rt;
    bit ut;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  typedef struct {
    bit    st;
    int    a;
    int    b;
    bit    dir;
    bit    dst;
    int    da;
    int    db;
    string tag;
  } exp_t;

  exp_t sb[$];
  // Instructions past ID, youngest first: [0] in EX, [d] is d stages older.
  ins_t inflight[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic ins_t nop();
    ins_t i;
    i = '{v: 0, rs: 0, rt: 0, ut: 0, rd: 0, rw: 0, mr: 0};
    return i;
  endfunction

  function automatic ins_t rtype(int rd, int rs, int rt);
    ins_t i;
    i = '{v: 1, rs: rs, rt: rt, ut: 1, rd: rd, rw: 1, mr: 0};
    return i;
  endfunction

  function automatic ins_t lw(int rd, int base);
    ins_t i;
    i = '{v: 1, rs: base, rt: rd, ut: 0, rd: rd, rw: 1, mr: 1};
    return i;
  endfunction

  // Result source for a register read by the instruction in EX: the
  // nearest older writer one stage ahead comes from EX/MEM, two from MEM/WB.
  function automatic int model_sel(int src);
    if (!inflight[0].v) return 0;
    for (int d = 1; d <= 2; d++) begin
      if (inflight[d].v && inflight[d].rw && inflight[d].rd != 0 && inflight[d].rd == src)
        return (d == 1) ? 2 : 1;
    end
    return 0;
  endfunction

  function automatic bit model_stall(ins_t id);
    ins_t ex;
    ex = inflight[0];
    return id.v && ex.v && ex.mr && ex.rw && ex.rd != 0 &&
           (ex.rd == id.rs || (id.ut && ex.rd == id.rt));
  endfunction

  task automatic model_clear();
    inflight.delete();
    repeat (3) inflight.push_back(nop());
  endtask

  task automatic model_advance(ins_t id, bit rst, bit st);
    if (rst) begin
      model_clear();
    end else begin
      inflight.push_front((st || !id.v) ? nop() : id);
      void'(inflight.pop_back());
    end
  endtask

  task automatic chk(string nm, logic [1:0] act, int req);
    n_checks++;
    if (act !== 2'(req)) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
    end
  endtask

  // One ID-stage cycle: drive, predict, then let the edge happen.
  task automatic step(ins_t ins, bit rst = 0, bit dir = 0, bit dst = 0,
                      int da = 0, int db = 0, string tag = "");
    exp_t e;
    rst_i         = rst;
    id_valid_i    = ins.v;
    id_rs_i       = W'(ins.rs);
    id_rt_i       = W'(ins.rt);
    id_uses_rt_i  = ins.ut;
    id_rd_i       = W'(ins.rd);
    id_regwrite_i = ins.rw;
    id_memread_i  = ins.mr;
    e.st  = model_stall(ins);
    e.a   = model_sel(inflight[0].rs);
    e.b   = model_sel(inflight[0].rt);
    e.dir = dir;
    e.dst = dst;
    e.da  = da;
    e.db  = db;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    model_advance(ins, rst, e.st);
  endtask

  task automatic flush();
    repeat (3) step(nop());
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued prediction.
  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("stall", {1'b0, stall_o}, int'(e.st));
      chk("fwd_a", ex_fwd_a_o, e.a);
      chk("fwd_b", ex_fwd_b_o, e.b);
      if (e.dir) begin
        chk({e.tag, "_stall"}, {1'b0, stall_o}, int'(e.dst));
        chk({e.tag, "_a"}, ex_fwd_a_o, e.da);
        chk({e.tag, "_b"}, ex_fwd_b_o, e.db);
      end
    end
  end

  initial begin
    ins_t r;
    rst_i = 1'b1;
    id_valid_i = 1'b0; id_rs_i = '0; id_rt_i = '0; id_uses_rt_i = 1'b0;
    id_rd_i = '0; id_regwrite_i = 1'b0; id_memread_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    model_clear();

    step(nop(), 0, 1, 0, 0, 0, "reset_state");

    // EX/MEM forwarding back-to-back
    flush();
    step(rtype(3, 1, 2));
    step(rtype(4, 3, 5), 0, 1, 0, 0, 0, "b2b_id");
    step(nop(), 0, 1, 0, 2, 0, "b2b_ex");

    // MEM/WB forwarding with one gap
    flush();
    step(rtype(3, 1, 2));
    step(nop());
    step(rtype(6, 7, 3));
    step(nop(), 0, 1, 0, 0, 1, "gap_ex");

    // Load-use: exactly one stall, then bubble, then MEM/WB forward
    flush();
    step(lw(8, 1));
    step(rtype(9, 8, 8), 0, 1, 1, 0, 0, "lu_stall");
    step(rtype(9, 8, 8), 0, 1, 0, 0, 0, "lu_bubble");
    step(nop(), 0, 1, 0, 1, 1, "lu_ex");

    // Two writers of r2: most recent wins; r0 never forwarded
    flush();
    step(rtype(2, 1, 1));
    step(rtype(2, 3, 4));
    step(rtype(10, 2, 0));
    step(nop(), 0, 1, 0, 2, 0, "mem_wins");

    // r0 as destination and source
    flush();
    step(rtype(0, 1, 2));
    step(rtype(5, 0, 0), 0, 1, 0, 0, 0, "r0_id");
    step(nop(), 0, 1, 0, 0, 0, "r0_ex");
    step(lw(0, 1));
    step(rtype(5, 0, 0), 0, 1, 0, 0, 0, "lw_r0_id");
    step(nop(), 0, 1, 0, 0, 0, "lw_r0_ex");

    // Reset during the stall cycle
    flush();
    step(lw(8, 1));
    step(rtype(9, 8, 8), 1, 1, 1, 0, 0, "rst_stall");
    step(rtype(9, 8, 8), 0, 1, 0, 0, 0, "rst_after");

    // Random traffic over a small register set to provoke hazards
    for (int n = 0; n < 600; n++) begin
      r.v  = ($urandom_range(0, 5) != 0);
      r.rs = $urandom_range(0, 7);
      r.rt = $urandom_range(0, 7);
      r.ut = $urandom_range(0, 1);
      r.rd = $urandom_range(0, 7);
      r.rw = ($urandom_range(0, 3) != 0);
      r.mr = $urandom_range(0, 1);
      step(r, ($urandom_range(0, 49) == 0));
    end
    step(nop());

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_i);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
